tc_out_stream: RTL and testbench
================================

Name: tc_out_stream

Overview:
- Downstream drain stage for the tensor-core result matrix.
- On a start pulse it snapshots the flat M x N result bus (row-major, DW_OUT per element) into an internal buffer.
- It then streams the buffer as fixed-width beats over a valid/ready handshake to the writeback/memory side.
- This frees the core to begin the next LOAD/COMPUTE pass while draining.

Parameters:
- M, 32, result rows
- N, 32, result columns
- DW_OUT, 8, bits per result element
- BEAT_ELEMS, 4, elements per output beat; must divide N
- N_BEATS, M*N/BEAT_ELEMS, beats per matrix (derived)
- DW_CNT, $clog2(N_BEATS), beat counter width (derived)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: capture in_mat and begin streaming
- abort  in  1  synchronous cancel of the current drain
- in_mat  in  M*N*DW_OUT  result matrix, element (r,c) at bits [(r*N+c)*DW_OUT +: DW_OUT]
- busy  out  1  high from the cycle after an accepted start until the DONE cycle completes
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts the beat
- out_data  out  BEAT_ELEMS*DW_OUT  beat payload; lowest-index element in the LSBs
- out_row  out  $clog2(M)  row of the first element in the beat
- out_col  out  $clog2(N)  column of the first element in the beat
- out_last  out  1  final beat of the matrix
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, beat counter=0.
  - busy, out_valid, out_last, done = 0; out_data, out_row, out_col = 0.
  - Buffer contents are don't-care.
- States:
  - IDLE: waits for start. Start accepted at edge t means the buffer is loaded from in_mat at t, state goes to STREAM, and counter=0. out_valid=1 and busy=1 are visible from cycle t+1.
  - STREAM: out_valid=1. Beat b carries buffer elements b*BEAT_ELEMS .. b*BEAT_ELEMS+BEAT_ELEMS-1 in row-major order. out_row = (b*BEAT_ELEMS)/N; out_col = (b*BEAT_ELEMS)%N. out_last = (b==N_BEATS-1).
  - Transfer occurs when out_valid && out_ready at a rising edge; the counter then increments. Transfer of the last beat moves the state to DONE.
  - DONE: out_valid=0, done=1 for exactly one cycle, busy=1; then IDLE. The counter returns to 0.
- Handshake rules:
  - While out_valid && !out_ready, out_data/out_row/out_col/out_last hold stable.
  - out_valid never drops without a transfer, except on abort or reset.
  - out_ready is ignored when out_valid=0.
  - No combinational path from out_ready to out_valid.
- Throughput and latency:
  - With out_ready held high, one beat per cycle. A full drain is N_BEATS cycles plus 1 DONE cycle.
  - Default drain: 256 beats, first beat at t+1, done at t+257.
- Snapshot: in_mat is sampled only at the start edge. Later changes to in_mat do not affect streamed data.
- start while busy (STREAM or DONE): ignored, with no re-capture. start on the same edge the DONE cycle ends: ignored; it must be re-issued in IDLE.
- abort:
  - Sampled at each edge in STREAM/DONE.
  - Goes to IDLE next cycle with out_valid=0, busy=0, counter=0, and no done pulse.
  - abort has priority over a simultaneous transfer.
  - abort together with start in IDLE: start is ignored.
- Reset mid-stream: immediate return to reset values. No partial done; no beat is reported.
- Arithmetic:
  - The counter never exceeds N_BEATS-1; no wrap inside STREAM.
  - The out_row/out_col computation must not overflow for the defaults: N_BEATS=256 needs an 8-bit counter.

Test Plan:
- Reset/idle: assert reset asynchronously mid-cycle -> all outputs 0 immediately; with start never pulsed, out_valid stays 0 for 50 cycles.
- Full drain, ready=1: in_mat element (r,c)=(r*N+c)&8'hFF, start at cycle 10 ->
  - beat 0 = 32'h03020100, row 0, col 0, at cycle 11;
  - beat 8 is row 1, col 0;
  - beat 255 = 32'hFFFEFDFC with out_last=1 at cycle 266;
  - done pulse at cycle 267; busy low at 268.
- Backpressure: out_ready random (about 50%) -> out_data stable whenever valid && !ready; all 256 beats received in order with no duplicates or gaps; done exactly once.
- Snapshot integrity: change in_mat to all 8'hAA one cycle after start -> streamed data still matches the pre-start matrix.
- start while busy / abort:
  - start pulses during STREAM -> no re-capture, beat count unaffected.
  - abort after beat 17 accepted -> out_valid 0 next cycle, no done pulse, busy 0.
  - New start then streams from beat 0.
- Reset mid-stream at beat 100 with ready=1 -> out_valid and busy 0 immediately; a following start restarts from row 0, col 0.

Source files
------------

// File: rtl/tc_out_stream.sv
// Drain stage for the tensor-core result matrix: snapshots the flat M x N result
// bus on start and streams it row-major as BEAT_ELEMS-wide beats over valid/ready.
module tc_out_stream #(
  parameter int M          = 32,
  parameter int N          = 32,
  parameter int DW_OUT     = 8,
  parameter int BEAT_ELEMS = 4,
  localparam int N_BEATS   = M * N / BEAT_ELEMS,
  localparam int DW_CNT    = $clog2(N_BEATS),
  localparam int RW        = $clog2(M),
  localparam int CW        = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [M*N*DW_OUT-1:0]        in_mat,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BEAT_ELEMS*DW_OUT-1:0] out_data,
  output logic [RW-1:0]                out_row,
  output logic [CW-1:0]                out_col,
  output logic                         out_last,
  output logic                         done
);

  localparam int BW = BEAT_ELEMS * DW_OUT;
  localparam int EW = $clog2(M * N);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic [DW_CNT-1:0]     r_cnt, w_cnt_n;
  logic [M*N*DW_OUT-1:0] r_buf;
  logic                  w_start_acc;
  logic                  w_xfer;
  logic                  w_last_beat;
  logic [EW-1:0]         w_elem;

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_last_beat = (r_cnt == DW_CNT'(N_BEATS - 1));
  assign w_xfer      = (r_state == S_STREAM) && out_ready && !abort;
  assign w_elem      = EW'(r_cnt) * EW'(BEAT_ELEMS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_start_acc)
      r_buf <= in_mat;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_state_n = S_STREAM;
          w_cnt_n   = '0;
        end
      end
      S_STREAM: begin
        if (abort) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (w_xfer) begin
          if (w_last_beat) begin
            w_state_n = S_DONE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + DW_CNT'(1);
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_STREAM);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    out_last  = '0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    if (r_state == S_STREAM) begin
      out_last = w_last_beat;
      out_data = r_buf[w_elem*DW_OUT +: BW];
      out_row  = RW'(w_elem / EW'(N));
      out_col  = CW'(w_elem % EW'(N));
    end
  end

endmodule

// File: tb/tb_tc_out_stream.sv
// Directed bench for tc_out_stream: reset, full drain, backpressure with snapshot,
// start-while-busy, abort and mid-stream reset.
module tb_tc_out_stream;

  localparam int M  = 32;
  localparam int N  = 32;
  localparam int DW = 8;
  localparam int BE = 4;
  localparam int NB = M * N / BE;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [M*N*DW-1:0] in_mat;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [BE*DW-1:0]  out_data;
  logic [4:0]        out_row;
  logic [4:0]        out_col;
  logic              out_last;
  logic              done;

  int checks = 0;
  int errors = 0;

  tc_out_stream #(.M(M), .N(N), .DW_OUT(DW), .BEAT_ELEMS(BE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .in_mat(in_mat),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {valid, last, row, col, data} for beat b of the (r*N+c)&FF pattern
  function automatic logic [63:0] exp_beat(input int b);
    logic [31:0] d;
    logic [4:0]  r;
    logic [4:0]  c;
    for (int k = 0; k < BE; k++) d[k*8 +: 8] = 8'((b * BE + k) & 255);
    r = 5'((b * BE) / N);
    c = 5'((b * BE) % N);
    return {20'd0, 1'b1, (b == NB - 1), r, c, d};
  endfunction

  function automatic logic [63:0] cur_beat();
    return {20'd0, out_valid, out_last, out_row, out_col, out_data};
  endfunction

  task automatic load_pattern;
    for (int i = 0; i < M * N; i++) in_mat[i*8 +: 8] = 8'(i & 255);
  endtask

  initial begin
    logic [63:0] prev_beat;
    logic        prev_stall;
    int          nb;
    int          ndone;
    logic        fin;

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    load_pattern();
    #3;
    chk("reset_outputs", {busy, out_valid, out_last, done, out_row, out_col, out_data}, '0);
    tick; tick;
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      chk($sformatf("idle_c%0d", i), {busy, out_valid, done}, '0);
      tick;
    end

    // Full drain with ready held high
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("drain_b%0d", b), cur_beat(), exp_beat(b));
      if (b == 0) chk("drain_busy", {63'd0, busy}, 64'd1);
      tick;
    end
    chk("drain_done", {done, out_valid, busy}, 64'b101);
    tick;
    chk("drain_after_done", {done, out_valid, busy}, '0);

    // Backpressure; in_mat is overwritten right after the start edge
    load_pattern();
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    in_mat = {(M*N){8'hAA}};
    nb = 0; ndone = 0; fin = 1'b0; prev_stall = 1'b0; prev_beat = '0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (prev_stall) chk($sformatf("bp_hold_b%0d", nb), cur_beat(), prev_beat);
      if (out_valid) chk($sformatf("bp_b%0d", nb), cur_beat(), exp_beat(nb));
      if (done) ndone++;
      if (!busy && ndone > 0) fin = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      prev_stall = out_valid && !out_ready;
      prev_beat = cur_beat();
      if (out_valid && out_ready) nb++;
      tick;
    end
    chk("bp_finished", {63'd0, fin}, 64'd1);
    chk("bp_beats", 64'(nb), 64'(NB));
    chk("bp_done_count", 64'(ndone), 64'd1);

    // start pulses during STREAM, then abort after beat 17
    load_pattern();
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    in_mat = {(M*N){8'hAA}};
    for (int b = 0; b < 18; b++) begin
      chk($sformatf("sb_b%0d", b), cur_beat(), exp_beat(b));
      start = (b == 5 || b == 6);
      tick;
    end
    start = 1'b0;
    chk("sb_b18", cur_beat(), exp_beat(18));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle", {done, out_valid, busy}, '0);
    tick;
    chk("abort_no_done", {done, out_valid, busy}, '0);

    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    chk("abort_start_ignored", {out_valid, busy}, '0);

    // Restart from beat 0, then reset asynchronously at beat 100
    load_pattern();
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int b = 0; b < 100; b++) begin
      chk($sformatf("rs_b%0d", b), cur_beat(), exp_beat(b));
      tick;
    end
    chk("rs_b100", cur_beat(), exp_beat(100));
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {busy, out_valid, out_last, done, out_row, out_col, out_data}, '0);
    #1;
    reset = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_b0", cur_beat(), exp_beat(0));
    tick;
    chk("restart_b1", cur_beat(), exp_beat(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
